gcu_dep_tracker: RTL and testbench

GCU_DEP_TRACKER -- requirements
Module: gcu_dep_tracker

---
 rtl/gcu_dep_tracker_pkg.sv | 17 +
 rtl/gcu_dep_tracker_if.sv | 40 ++++
 rtl/gcu_dep_tracker_prio_enc.sv | 24 ++
 rtl/gcu_dep_tracker.sv | 164 ++++++++++++++++
 tb/tb_gcu_dep_tracker.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcu_dep_tracker_pkg.sv
// Shared types and default sizing for the graph-compute dependency tracker.
package gcu_pkg;

    localparam int NODE_ID_W_DEF         = 10;
    localparam int MAX_NODES_DEF         = 1024;
    localparam int CHILD_CNT_W_DEF       = 16;
    localparam int NUM_SCATTER_PORTS_DEF = 4;

    typedef logic [NODE_ID_W_DEF-1:0]   node_id_t;
    typedef logic [CHILD_CNT_W_DEF-1:0] child_cnt_t;

    // Width needed to hold 0..ports simultaneous hits on one node.
    function automatic int hit_cnt_w(input int ports);
        return $clog2(ports + 1);
    endfunction

endpackage

// File: rtl/gcu_dep_tracker_if.sv
// Init / scatter / retire / query / ready signal bundle of the dependency tracker.
interface gcu_dep_tracker_if #(
    parameter int NODE_ID_W         = gcu_pkg::NODE_ID_W_DEF,
    parameter int CHILD_CNT_W       = gcu_pkg::CHILD_CNT_W_DEF,
    parameter int NUM_SCATTER_PORTS = gcu_pkg::NUM_SCATTER_PORTS_DEF
) ();

    logic                                   init_valid;
    logic [NODE_ID_W-1:0]                   init_node_id;
    logic [CHILD_CNT_W-1:0]                 init_children_count;
    logic [NUM_SCATTER_PORTS-1:0]           scatter_done_valid;
    logic [NUM_SCATTER_PORTS*NODE_ID_W-1:0] scatter_done_parent_id;
    logic                                   retire_valid;
    logic [NODE_ID_W-1:0]                   retire_node_id;
    logic [NODE_ID_W-1:0]                   query_node_id;
    logic                                   query_front_ready;
    logic [CHILD_CNT_W-1:0]                 query_count;
    logic                                   ready_valid;
    logic [NODE_ID_W-1:0]                   ready_node_id;
    logic                                   ready_ack;
    logic                                   err_underflow;
    logic                                   err_init_collision;

    modport master (
        output init_valid, init_node_id, init_children_count,
        output scatter_done_valid, scatter_done_parent_id,
        output retire_valid, retire_node_id, query_node_id, ready_ack,
        input  query_front_ready, query_count, ready_valid, ready_node_id,
        input  err_underflow, err_init_collision
    );

    modport slave (
        input  init_valid, init_node_id, init_children_count,
        input  scatter_done_valid, scatter_done_parent_id,
        input  retire_valid, retire_node_id, query_node_id, ready_ack,
        output query_front_ready, query_count, ready_valid, ready_node_id,
        output err_underflow, err_init_collision
    );

endinterface

// File: rtl/gcu_dep_tracker_prio_enc.sv
// Lowest-set-bit finder: picks the lowest-index requesting node and flags whether any requested.
module gcu_prio_enc #(
    parameter int WIDTH = gcu_pkg::MAX_NODES_DEF,
    parameter int IDX_W = gcu_pkg::NODE_ID_W_DEF
) (
    input  logic [WIDTH-1:0] req_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    always_comb begin
        // NOTE: combinational outputs get a default before any branch so no path leaves them unassigned (no latch).
        found_o = 1'b0;
        idx_o   = '0;
        // NOTE: blocking assignments in combinational logic; scanning downward lets the lowest index win last.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/gcu_dep_tracker.sv
// Per-node pending-children tracker: scatter completions count parents down to zero,
// zero-count nodes are emitted one per cycle in lowest-index order.
module gcu_dep_tracker #(
    parameter int NODE_ID_W         = gcu_pkg::NODE_ID_W_DEF,
    parameter int MAX_NODES         = gcu_pkg::MAX_NODES_DEF,
    parameter int CHILD_CNT_W       = gcu_pkg::CHILD_CNT_W_DEF,
    parameter int NUM_SCATTER_PORTS = gcu_pkg::NUM_SCATTER_PORTS_DEF
) (
    input logic              clk,
    input logic              rst,
    gcu_dep_tracker_if.slave dep_if
);

    import gcu_pkg::*;

    localparam int HIT_W = hit_cnt_w(NUM_SCATTER_PORTS);

    logic [MAX_NODES-1:0]   live_q, live_d;
    logic [MAX_NODES-1:0]   pend_q, pend_d;
    logic [CHILD_CNT_W-1:0] count_q [MAX_NODES];
    logic [CHILD_CNT_W-1:0] count_d [MAX_NODES];

    logic                   ready_valid_q, ready_valid_d;
    logic [NODE_ID_W-1:0]   ready_id_q, ready_id_d;
    logic                   query_front_q, query_front_d;
    logic [CHILD_CNT_W-1:0] query_count_q, query_count_d;
    logic                   err_uf_q, err_uf_d;
    logic                   err_coll_q, err_coll_d;

    logic [MAX_NODES-1:0]   init_sel;
    logic [MAX_NODES-1:0]   retire_sel;
    logic [MAX_NODES-1:0]   cand;
    logic [MAX_NODES-1:0]   grant;
    logic                   found;
    logic [NODE_ID_W-1:0]   found_idx;
    logic                   retire_eff;
    logic                   cancel;

    // Nodes being inited or retired this cycle are not eligible for emission; init beats retire.
    always_comb begin
        init_sel   = '0;
        retire_sel = '0;
        for (int n = 0; n < MAX_NODES; n++) begin
            init_sel[n]   = dep_if.init_valid && (dep_if.init_node_id == NODE_ID_W'(n));
            retire_sel[n] = dep_if.retire_valid && (dep_if.retire_node_id == NODE_ID_W'(n))
                            && !init_sel[n];
        end
        cand = pend_q & ~init_sel & ~retire_sel;
    end

    gcu_prio_enc #(
        .WIDTH (MAX_NODES),
        .IDX_W (NODE_ID_W)
    ) u_prio_enc (
        .req_i   (cand),
        .found_o (found),
        .idx_o   (found_idx)
    );

    always_comb begin
        retire_eff    = dep_if.retire_valid
                        && !(dep_if.init_valid && (dep_if.init_node_id == dep_if.retire_node_id));
        cancel        = ready_valid_q && retire_eff && (dep_if.retire_node_id == ready_id_q);
        ready_valid_d = ready_valid_q;
        ready_id_d    = ready_id_q;
        grant         = '0;
        if (cancel) begin
            ready_valid_d = 1'b0;
        end else if (!ready_valid_q || dep_if.ready_ack) begin
            ready_valid_d = found;
            if (found) begin
                ready_id_d       = found_idx;
                grant[found_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        logic [HIT_W-1:0] hits;
        live_d        = live_q;
        pend_d        = pend_q & ~grant;
        count_d       = count_q;
        err_uf_d      = err_uf_q;
        err_coll_d    = err_coll_q;
        query_front_d = 1'b0;
        query_count_d = '0;
        for (int n = 0; n < MAX_NODES; n++) begin
            hits = '0;
            for (int k = 0; k < NUM_SCATTER_PORTS; k++) begin
                if (dep_if.scatter_done_valid[k]
                    && (dep_if.scatter_done_parent_id[k*NODE_ID_W +: NODE_ID_W] == NODE_ID_W'(n))) begin
                    hits = hits + HIT_W'(1);
                end
            end

            if (init_sel[n]) begin
                live_d[n]  = 1'b1;
                count_d[n] = dep_if.init_children_count;
                pend_d[n]  = (dep_if.init_children_count == '0);
                if (hits != '0) begin
                    err_coll_d = 1'b1;
                end
            end else if (retire_sel[n]) begin
                live_d[n]  = 1'b0;
                count_d[n] = '0;
                pend_d[n]  = 1'b0;
            end else if (hits != '0) begin
                if (!live_q[n]) begin
                    err_uf_d = 1'b1;
                end else if (count_q[n] <= CHILD_CNT_W'(hits)) begin
                    // Reaching zero from a positive count is what makes a node ready.
                    if (count_q[n] < CHILD_CNT_W'(hits)) begin
                        err_uf_d = 1'b1;
                    end
                    if (count_q[n] != '0) begin
                        pend_d[n] = 1'b1;
                    end
                    count_d[n] = '0;
                end else begin
                    count_d[n] = count_q[n] - CHILD_CNT_W'(hits);
                end
            end

            if ((dep_if.query_node_id == NODE_ID_W'(n)) && live_d[n]) begin
                query_front_d = (count_d[n] == '0);
                query_count_d = count_d[n];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q        <= '0;
            pend_q        <= '0;
            // NOTE: the count array is flop-based and must be cleared on reset, so it is reset like any register.
            count_q       <= '{default: '0};
            ready_valid_q <= 1'b0;
            ready_id_q    <= '0;
            query_front_q <= 1'b0;
            query_count_q <= '0;
            err_uf_q      <= 1'b0;
            err_coll_q    <= 1'b0;
        end else begin
            live_q        <= live_d;
            pend_q        <= pend_d;
            count_q       <= count_d;
            ready_valid_q <= ready_valid_d;
            ready_id_q    <= ready_id_d;
            query_front_q <= query_front_d;
            query_count_q <= query_count_d;
            err_uf_q      <= err_uf_d;
            err_coll_q    <= err_coll_d;
        end
    end

    assign dep_if.ready_valid        = ready_valid_q;
    assign dep_if.ready_node_id      = ready_id_q;
    assign dep_if.query_front_ready  = query_front_q;
    assign dep_if.query_count        = query_count_q;
    assign dep_if.err_underflow      = err_uf_q;
    assign dep_if.err_init_collision = err_coll_q;

endmodule

// File: tb/tb_gcu_dep_tracker.sv
// Directed bench for gcu_dep_tracker: per-cycle comparison against a behavioural node model
// plus literal expectations at the key points of each scenario.
module tb_gcu_dep_tracker;

    import gcu_pkg::*;

    localparam int NW = NODE_ID_W_DEF;
    localparam int NN = MAX_NODES_DEF;
    localparam int CW = CHILD_CNT_W_DEF;
    localparam int NP = NUM_SCATTER_PORTS_DEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gcu_dep_tracker_if dep_if ();

    gcu_dep_tracker dut (
        .clk    (clk),
        .rst    (rst),
        .dep_if (dep_if)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Behavioural model: one record per node, channels applied one at a time.
    bit m_live [NN];
    int m_cnt  [NN];
    bit m_pend [NN];
    bit m_rv;
    int m_rid;
    bit m_qfr;
    int m_qcnt;
    bit m_uf;
    bit m_coll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model_step
        int init_n;
        int ret_n;
        int p;
        int q;
        if (rst) begin
            for (int i = 0; i < NN; i++) begin
                m_live[i] = 1'b0;
                m_cnt[i]  = 0;
                m_pend[i] = 1'b0;
            end
            m_rv   = 1'b0;
            m_rid  = 0;
            m_qfr  = 1'b0;
            m_qcnt = 0;
            m_uf   = 1'b0;
            m_coll = 1'b0;
        end else begin
            init_n = dep_if.init_valid ? int'(dep_if.init_node_id) : -1;
            ret_n  = (dep_if.retire_valid && (init_n != int'(dep_if.retire_node_id)))
                     ? int'(dep_if.retire_node_id) : -1;

            if (m_rv && ret_n == m_rid) begin
                m_rv = 1'b0;
            end else if (!m_rv || dep_if.ready_ack) begin
                m_rv = 1'b0;
                for (int i = 0; i < NN; i++) begin
                    if (m_pend[i] && i != init_n && i != ret_n) begin
                        m_rv      = 1'b1;
                        m_rid     = i;
                        m_pend[i] = 1'b0;
                        break;
                    end
                end
            end

            for (int k = 0; k < NP; k++) begin
                if (dep_if.scatter_done_valid[k]) begin
                    p = int'(dep_if.scatter_done_parent_id[k*NW +: NW]);
                    if (p == init_n) begin
                        m_coll = 1'b1;
                    end else if (p == ret_n) begin
                    end else if (!m_live[p] || m_cnt[p] == 0) begin
                        m_uf = 1'b1;
                    end else begin
                        m_cnt[p] = m_cnt[p] - 1;
                        if (m_cnt[p] == 0) m_pend[p] = 1'b1;
                    end
                end
            end

            if (init_n >= 0) begin
                m_live[init_n] = 1'b1;
                m_cnt[init_n]  = int'(dep_if.init_children_count);
                m_pend[init_n] = (dep_if.init_children_count == '0);
            end
            if (ret_n >= 0) begin
                m_live[ret_n] = 1'b0;
                m_cnt[ret_n]  = 0;
                m_pend[ret_n] = 1'b0;
            end

            q      = int'(dep_if.query_node_id);
            m_qfr  = m_live[q] && (m_cnt[q] == 0);
            m_qcnt = m_live[q] ? m_cnt[q] : 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_ready_valid", dep_if.ready_valid, m_rv);
            if (m_rv) check("model_ready_id", dep_if.ready_node_id, m_rid);
            check("model_query_front", dep_if.query_front_ready, m_qfr);
            check("model_query_count", dep_if.query_count, m_qcnt);
            check("model_err_underflow", dep_if.err_underflow, m_uf);
            check("model_err_collision", dep_if.err_init_collision, m_coll);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        dep_if.init_valid             = 1'b0;
        dep_if.init_node_id           = '0;
        dep_if.init_children_count    = '0;
        dep_if.scatter_done_valid     = '0;
        dep_if.scatter_done_parent_id = '0;
        dep_if.retire_valid           = 1'b0;
        dep_if.retire_node_id         = '0;
        dep_if.ready_ack              = 1'b0;
    endtask

    task automatic do_init(input int id, input int cnt);
        dep_if.init_valid          = 1'b1;
        dep_if.init_node_id        = NW'(id);
        dep_if.init_children_count = CW'(cnt);
    endtask

    task automatic do_scatter(input logic [NP-1:0] mask, input int id);
        dep_if.scatter_done_valid = mask;
        for (int k = 0; k < NP; k++) begin
            if (mask[k]) dep_if.scatter_done_parent_id[k*NW +: NW] = NW'(id);
        end
    endtask

    task automatic set_query(input int id);
        dep_if.query_node_id = NW'(id);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready_valid"}, dep_if.ready_valid, 0);
        check({tag, "_ready_id"}, dep_if.ready_node_id, 0);
        check({tag, "_query_front"}, dep_if.query_front_ready, 0);
        check({tag, "_query_count"}, dep_if.query_count, 0);
        check({tag, "_err_underflow"}, dep_if.err_underflow, 0);
        check({tag, "_err_collision"}, dep_if.err_init_collision, 0);
    endtask

    initial begin
        rst = 1'b1;
        set_query(0);
        idle();
        repeat (3) cyc();
        check_all_zero("reset");
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Three channels retire all children of node 5 in a single cycle.
        set_query(5);
        do_init(5, 3);
        cyc();
        check("r19_count_after_init", dep_if.query_count, 3);
        check("r19_front_after_init", dep_if.query_front_ready, 0);
        idle();
        do_scatter(4'b0111, 5);
        cyc();
        check("r19_count_zero", dep_if.query_count, 0);
        check("r19_front_ready", dep_if.query_front_ready, 1);
        check("r19_not_yet_ready", dep_if.ready_valid, 0);
        idle();
        cyc();
        check("r19_ready_valid", dep_if.ready_valid, 1);
        check("r19_ready_id", dep_if.ready_node_id, 5);
        dep_if.ready_ack = 1'b1;
        cyc();
        check("r19_drained", dep_if.ready_valid, 0);

        // Two zero-count nodes: the held emission stays put until acked.
        idle();
        do_init(2, 0);
        cyc();
        idle();
        do_init(7, 0);
        cyc();
        check("r20_first_valid", dep_if.ready_valid, 1);
        check("r20_first_id", dep_if.ready_node_id, 2);
        idle();
        cyc();
        check("r20_hold_1", dep_if.ready_node_id, 2);
        cyc();
        check("r20_hold_2", dep_if.ready_node_id, 2);
        check("r20_hold_valid", dep_if.ready_valid, 1);
        dep_if.ready_ack = 1'b1;
        cyc();
        check("r20_second_id", dep_if.ready_node_id, 7);
        check("r20_second_valid", dep_if.ready_valid, 1);
        cyc();
        check("r20_empty", dep_if.ready_valid, 0);
        idle();

        // Init and scatter collide on node 4: init wins.
        set_query(4);
        do_init(4, 2);
        do_scatter(4'b0010, 4);
        cyc();
        check("r22_count", dep_if.query_count, 2);
        check("r22_collision", dep_if.err_init_collision, 1);
        check("r22_no_underflow", dep_if.err_underflow, 0);
        idle();
        cyc();
        check("r22_no_ready_1", dep_if.ready_valid, 0);
        cyc();
        check("r22_no_ready_2", dep_if.ready_valid, 0);

        // Scatter on a node that was never inited.
        set_query(12);
        do_scatter(4'b0100, 12);
        cyc();
        check("r23_underflow", dep_if.err_underflow, 1);
        check("r23_query_count", dep_if.query_count, 0);
        check("r23_query_front", dep_if.query_front_ready, 0);
        idle();
        rst = 1'b1;
        cyc();
        check("rst_clears_underflow", dep_if.err_underflow, 0);
        check("rst_clears_collision", dep_if.err_init_collision, 0);
        rst = 1'b0;

        // Two hits on a count of one saturate and still emit exactly once.
        set_query(9);
        do_init(9, 1);
        cyc();
        check("r21_count_one", dep_if.query_count, 1);
        idle();
        do_scatter(4'b1001, 9);
        cyc();
        check("r21_count_zero", dep_if.query_count, 0);
        check("r21_front", dep_if.query_front_ready, 1);
        check("r21_underflow", dep_if.err_underflow, 1);
        idle();
        cyc();
        check("r21_ready_valid", dep_if.ready_valid, 1);
        check("r21_ready_id", dep_if.ready_node_id, 9);
        dep_if.ready_ack = 1'b1;
        cyc();
        check("r21_drained", dep_if.ready_valid, 0);
        dep_if.ready_ack = 1'b0;
        cyc();
        check("r21_single_emit_1", dep_if.ready_valid, 0);
        cyc();
        check("r21_single_emit_2", dep_if.ready_valid, 0);

        // Retiring the node held in the ready register cancels the emission.
        set_query(5);
        do_init(5, 0);
        cyc();
        idle();
        cyc();
        check("r23_held_valid", dep_if.ready_valid, 1);
        check("r23_held_id", dep_if.ready_node_id, 5);
        dep_if.retire_valid   = 1'b1;
        dep_if.retire_node_id = NW'(5);
        cyc();
        check("r23_cancelled", dep_if.ready_valid, 0);
        check("r23_retired_front", dep_if.query_front_ready, 0);
        check("r23_retired_count", dep_if.query_count, 0);
        idle();

        // Reset during an active emission with a live nonzero count.
        set_query(8);
        do_init(6, 0);
        cyc();
        idle();
        do_init(8, 5);
        cyc();
        check("r24_pre_valid", dep_if.ready_valid, 1);
        check("r24_pre_id", dep_if.ready_node_id, 6);
        check("r24_pre_count", dep_if.query_count, 5);
        idle();
        rst = 1'b1;
        do_init(10, 0);
        cyc();
        check_all_zero("r24_reset");
        rst = 1'b0;
        idle();
        cyc();
        check("r24_count_discarded", dep_if.query_count, 0);
        check("r24_no_ready", dep_if.ready_valid, 0);
        set_query(11);
        do_init(11, 2);
        cyc();
        check("r24_fresh_count", dep_if.query_count, 2);
        idle();
        do_scatter(4'b0011, 11);
        cyc();
        check("r24_fresh_front", dep_if.query_front_ready, 1);
        check("r24_fresh_zero", dep_if.query_count, 0);
        idle();
        cyc();
        check("r24_fresh_valid", dep_if.ready_valid, 1);
        check("r24_fresh_id", dep_if.ready_node_id, 11);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
